// File: rtl/cache_bus_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the memory port.
// The arbiter uses the slave view; the cache/memory side uses the master view.
interface cache_bus_arbiter_if;
  // instruction-cache requester (read-only bursts)
  logic        HRequestI;
  logic [31:0] HAddrI;
  // data-cache requester (writeback and fill bursts)
  logic        HRequestM;
  logic        HWriteM;
  logic [31:0] HAddrM;
  logic [31:0] HWDataM;
  // memory side
  logic        BusReady;
  logic        HRequest;
  logic        HWrite;
  logic [31:0] HAddr;
  logic [31:0] HWData;
  // per-requester status
  logic        BusReadyI;
  logic        BusReadyM;
  logic        GrantI;
  logic        GrantM;
  logic [1:0]  BeatCount;

  modport slave (
    input  HRequestI, HAddrI, HRequestM, HWriteM, HAddrM, HWDataM, BusReady,
    output HRequest, HWrite, HAddr, HWData, BusReadyI, BusReadyM,
           GrantI, GrantM, BeatCount
  );

  modport master (
    output HRequestI, HAddrI, HRequestM, HWriteM, HAddrM, HWDataM, BusReady,
    input  HRequest, HWrite, HAddr, HWData, BusReadyI, BusReadyM,
           GrantI, GrantM, BeatCount
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-requester memory bus arbiter (I-cache vs D-cache).
// Registered arbitration in IDLE, D-cache priority with a starvation guard
// that hands the bus to the I-cache after two consecutive D-cache wins.
// A grant stays locked while the owner keeps its request high, so a D-cache
// writeback followed by a fill runs as one uninterrupted 8-beat transaction.
module cache_bus_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  cache_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_M = 2'd2
  } state_t;

  // owner-side view of the bus, muxed from whichever cache holds the grant
  typedef struct packed {
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } owner_req_t;

  localparam logic [1:0] STARVE_MAX = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] starve_q, starve_d;
  owner_req_t own;

  // state, beat index and starvation counter; reset aborts any burst
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      starve_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  // select the current owner's request fields; nothing when idle
  always_comb begin
    own = '0;
    unique case (state_q)
      GRANT_I: begin
        own.req   = bus.HRequestI;
        own.write = 1'b0;
        own.addr  = bus.HAddrI;
        own.wdata = 32'd0;
      end
      GRANT_M: begin
        own.req   = bus.HRequestM;
        own.write = bus.HWriteM;
        own.addr  = bus.HAddrM;
        own.wdata = bus.HWDataM;
      end
      default: own = '0;
    endcase
  end

  // next state: arbitrate in IDLE, hold while owner requests, abort on drop
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        // BusReady is deliberately ignored here; beat index stays parked at 0
        beat_d = 2'd0;
        if (bus.HRequestM && !(bus.HRequestI && starve_q == STARVE_MAX)) begin
          state_d = GRANT_M;
          // only count a win as starvation if the I-cache was actually waiting
          if (bus.HRequestI && starve_q != STARVE_MAX)
            starve_d = starve_q + 2'd1;
        end else if (bus.HRequestI) begin
          state_d  = GRANT_I;
          starve_d = 2'd0;
        end
      end
      GRANT_I, GRANT_M: begin
        if (!own.req) begin
          // mid-burst drop is a silent abort
          state_d = IDLE;
          beat_d  = 2'd0;
        end else if (bus.BusReady) begin
          // natural 3->0 wrap lets a locked grant roll into the next burst
          beat_d = beat_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // bus outputs come from state and owner inputs only; BusReady only feeds strobes
  always_comb begin
    bus.GrantI    = (state_q == GRANT_I);
    bus.GrantM    = (state_q == GRANT_M);
    bus.HRequest  = own.req;
    bus.HWrite    = own.write;
    bus.HAddr     = own.addr;
    bus.HWData    = own.wdata;
    bus.BusReadyI = bus.BusReady & (state_q == GRANT_I);
    bus.BusReadyM = bus.BusReady & (state_q == GRANT_M);
    bus.BeatCount = beat_q;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a transaction-level model is checked
// against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_cache_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_bus_arbiter_if b();

  cache_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 I, 2 D), beats completed in the
  // current transaction, and how many D wins in a row the I-cache has waited.
  int m_owner  = 0;
  int m_beats  = 0;
  int m_starve = 0;
  bit started  = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      m_owner  <= 0;
      m_beats  <= 0;
      m_starve <= 0;
    end else if (m_owner == 0) begin
      m_beats <= 0;
      if (b.HRequestM && !(b.HRequestI && m_starve >= 2)) begin
        m_owner <= 2;
        if (b.HRequestI) m_starve <= (m_starve >= 2) ? 2 : m_starve + 1;
      end else if (b.HRequestI) begin
        m_owner  <= 1;
        m_starve <= 0;
      end
    end else begin
      if (!((m_owner == 1) ? b.HRequestI : b.HRequestM)) begin
        m_owner <= 0;
        m_beats <= 0;
      end else if (b.BusReady) begin
        m_beats <= m_beats + 1;
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      logic        e_req, e_wr;
      logic [31:0] e_addr, e_wd;
      e_req  = (m_owner == 1) ? b.HRequestI : (m_owner == 2) ? b.HRequestM : 1'b0;
      e_wr   = (m_owner == 2) ? b.HWriteM : 1'b0;
      e_addr = (m_owner == 1) ? b.HAddrI : (m_owner == 2) ? b.HAddrM : 32'd0;
      e_wd   = (m_owner == 2) ? b.HWDataM : 32'd0;
      check("model GrantI",    32'(b.GrantI),    32'(m_owner == 1));
      check("model GrantM",    32'(b.GrantM),    32'(m_owner == 2));
      check("model HRequest",  32'(b.HRequest),  32'(e_req));
      check("model HWrite",    32'(b.HWrite),    32'(e_wr));
      check("model HAddr",     b.HAddr,          e_addr);
      check("model HWData",    b.HWData,         e_wd);
      check("model BusReadyI", 32'(b.BusReadyI), 32'(b.BusReady && m_owner == 1));
      check("model BusReadyM", 32'(b.BusReadyM), 32'(b.BusReady && m_owner == 2));
      check("model BeatCount", 32'(b.BeatCount), 32'(m_beats % 4));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    b.HRequestI = 0; b.HAddrI = 32'h0;
    b.HRequestM = 0; b.HWriteM = 0; b.HAddrM = 32'h0; b.HWDataM = 32'h0;
    b.BusReady  = 0;
    reset = 0;
    step(); step();
    check("reset GrantI",   32'(b.GrantI),   0);
    check("reset GrantM",   32'(b.GrantM),   0);
    check("reset HRequest", 32'(b.HRequest), 0);
    check("reset BeatCnt",  32'(b.BeatCount), 0);

    // release with no request: must stay idle
    reset = 1;
    step();
    check("idle no grant", 32'({b.GrantI, b.GrantM}), 0);

    // I-cache 4-beat read, D-cache wiggles its request mid-burst
    b.HRequestI = 1; b.HAddrI = 32'h100;
    step();
    check("I grant", 32'(b.GrantI), 1);
    check("I addr",  b.HAddr, 32'h100);
    b.BusReady = 1;
    for (int k = 0; k < 4; k++) begin
      b.HRequestM = (k == 1 || k == 2);
      b.HAddrM    = 32'hDEAD0000 + 32'(k);
      settle();
      check("I beat",   32'(b.BeatCount), 32'(k));
      check("I strobe", 32'(b.BusReadyI), 1);
      check("I no M strobe", 32'(b.BusReadyM), 0);
      step();
    end
    check("I wrap", 32'(b.BeatCount), 0);
    b.HRequestI = 0; b.HRequestM = 0; b.BusReady = 0;
    step();
    check("I done idle", 32'({b.GrantI, b.GrantM}), 0);

    // both request: D wins twice, then I wins on the third arbitration
    b.HRequestI = 1; b.HAddrI = 32'h200;
    b.HRequestM = 1; b.HAddrM = 32'hA0; b.HWDataM = 32'h55; b.BusReady = 1;
    step();
    check("both -> M",   32'(b.GrantM), 1);
    check("M addr",      b.HAddr, 32'hA0);
    check("no I strobe", 32'(b.BusReadyI), 0);
    b.HRequestM = 0;
    step();
    b.HRequestM = 1;
    step();
    check("second M win", 32'(b.GrantM), 1);
    b.HRequestM = 0;
    step();
    b.HRequestM = 1;
    step();
    check("starve -> I", 32'(b.GrantI), 1);
    check("starve addr", b.HAddr, 32'h200);
    b.HRequestI = 0; b.HRequestM = 0;
    step();
    b.HRequestI = 1; b.HRequestM = 1;
    step();
    check("starve cleared", 32'(b.GrantM), 1);
    b.HRequestI = 0; b.HRequestM = 0; b.BusReady = 0;
    step();

    // locked 8-beat D transaction: 4 writes then 4 reads
    b.HRequestM = 1; b.HWriteM = 1; b.HAddrM = 32'h1000;
    step();
    b.BusReady = 1;
    for (int k = 0; k < 8; k++) begin
      b.HWriteM = (k < 4);
      b.HWDataM = 32'hC0DE0000 + 32'(k);
      b.HAddrM  = 32'h1000 + 32'(4 * k);
      settle();
      check("lock grant",  32'(b.GrantM), 1);
      check("lock write",  32'(b.HWrite), 32'(k < 4));
      check("lock beat",   32'(b.BeatCount), 32'(k % 4));
      step();
    end
    b.HRequestM = 0; b.BusReady = 0;
    step();
    check("lock end idle", 32'(b.GrantM), 0);

    // reset mid-burst at beat 2
    b.HRequestM = 1;
    step();
    b.BusReady = 1;
    step(); step();
    check("pre-reset beat", 32'(b.BeatCount), 2);
    reset = 0;
    step();
    check("rst GrantM",   32'(b.GrantM), 0);
    check("rst BeatCnt",  32'(b.BeatCount), 0);
    check("rst HRequest", 32'(b.HRequest), 0);
    step();
    check("rst held", 32'(b.GrantM), 0);
    reset = 1; b.HRequestM = 0;
    step();
    check("rst release idle", 32'(b.GrantM), 0);

    // drop at beat 1, then BusReady in IDLE is ignored
    b.HRequestM = 1; b.BusReady = 1;
    step();
    step();
    check("drop beat1", 32'(b.BeatCount), 1);
    b.HRequestM = 0;
    step();
    check("drop idle",   32'(b.GrantM), 0);
    check("drop beat0",  32'(b.BeatCount), 0);
    check("idle strobe", 32'({b.BusReadyI, b.BusReadyM}), 0);
    step();
    check("idle beat hold", 32'(b.BeatCount), 0);
    b.BusReady = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
